// File: rtl/bmm150_spi_pkg.sv
// rtl/bmm150_spi_pkg.sv - shared state type and frame constants for the BMM150 SPI engine
package bmm150_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP
  } spi_state_t;

  localparam int CMD_BITS = 8;
  localparam int BURST_BYTES = 8;
  localparam logic [6:0] REG_DATA_X_LSB = 7'h42;
  localparam int MAX_BITS = CMD_BITS + 8 * BURST_BYTES;

  // Index of the final SCLK bit of a frame: command byte plus one or eight data bytes.
  function automatic logic [6:0] last_bit_idx(input logic is_burst);
    return is_burst ? 7'(MAX_BITS - 1) : 7'(CMD_BITS + 8 - 1);
  endfunction

endpackage

// File: rtl/bmm150_spi_engine_if.sv
// rtl/bmm150_spi_engine_if.sv - request/response bus between the command FSM and the SPI engine
interface bmm150_spi_engine_if;

  logic        enable;
  logic        start;
  logic        burst;
  logic        rw;
  logic [6:0]  reg_addr;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data;
  logic [63:0] burst_data;
  logic        busy;
  logic        done;

  modport master (
    output enable, start, burst, rw, reg_addr, tx_data,
    input  rx_data, burst_data, busy, done
  );

  modport slave (
    input  enable, start, burst, rw, reg_addr, tx_data,
    output rx_data, burst_data, busy, done
  );

endinterface

// File: rtl/bmm150_sclk_tick.sv
// rtl/bmm150_sclk_tick.sv - half-period counter producing SCLK fall/rise strobes
module bmm150_sclk_tick #(
  parameter int HALF = 25
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;
  logic          phase_hi;
  logic          wrap;

  // phase_hi marks a half-period where SCLK is (or would be) high, so its wrap is a fall point.
  assign wrap      = en && (cnt == CW'(HALF - 1));
  assign fall_tick = wrap && phase_hi;
  assign rise_tick = wrap && !phase_hi;

  // Count half periods while a transfer runs; idle or abort restarts from a high phase.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      phase_hi <= 1'b1;
    end else if (!en) begin
      cnt      <= '0;
      phase_hi <= 1'b1;
    end else if (wrap) begin
      cnt      <= '0;
      phase_hi <= ~phase_hi;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bmm150_spi_engine.sv
// rtl/bmm150_spi_engine.sv - SPI mode 3 master for BMM150 single/burst register access (option: BMM150_SPI_LOOPBACK_EN)
module bmm150_spi_engine
  import bmm150_spi_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SPI_CLK = 1_000_000
) (
  input  logic                       clk,
  input  logic                       nrst,
  bmm150_spi_engine_if.slave         bus,
  output logic                       sclk,
  output logic                       mosi,
  input  logic                       miso,
  output logic                       cs_n
);

  localparam int HALF = CLK_HZ / (2 * SPI_CLK);

  if (HALF < 2) begin : g_bad_half
    $error("bmm150_spi_engine: CLK_HZ/(2*SPI_CLK) must be at least 2");
  end

  spi_state_t  state;
  logic        burst_q;
  logic        rw_q;
  logic [6:0]  bit_cnt;
  logic [71:0] tx_sr;
  logic [63:0] rx_sr;
  logic        fall_tick;
  logic        rise_tick;
  logic        tick_en;
  logic        sample_bit;

  assign tick_en = (state != ST_IDLE) && bus.enable;

  bmm150_sclk_tick #(.HALF(HALF)) u_tick (
    .clk       (clk),
    .nrst      (nrst),
    .en        (tick_en),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

`ifdef BMM150_SPI_LOOPBACK_EN
  // Self-test: read back what is being driven; the sensor pin is not consulted.
  assign sample_bit = mosi;
`else
  logic miso_meta;
  logic miso_sync;

  // Two-flop synchroniser for the asynchronous sensor data line.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  assign sample_bit = miso_sync;
`endif

  // Transaction sequencer: chip-select framing, SCLK shaping, bit shifting and result capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= ST_IDLE;
      sclk           <= 1'b1;
      cs_n           <= 1'b1;
      mosi           <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.rx_data    <= '0;
      bus.burst_data <= '0;
      burst_q        <= 1'b0;
      rw_q           <= 1'b0;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
    end else begin
      bus.done <= 1'b0;
      if ((state != ST_IDLE) && !bus.enable) begin
        // Abort: release the bus at once and drop the transfer without a completion.
        state    <= ST_IDLE;
        cs_n     <= 1'b1;
        sclk     <= 1'b1;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.enable && bus.start) begin
              state    <= ST_CS_SETUP;
              cs_n     <= 1'b0;
              bus.busy <= 1'b1;
              rw_q     <= bus.rw;
              burst_q  <= bus.burst && bus.rw;
              bit_cnt  <= '0;
              // Bit 0 (rw) goes out with chip select; the rest queue MSB first, data zero on reads.
              mosi     <= bus.rw;
              tx_sr    <= {bus.reg_addr, (bus.rw ? 8'h00 : bus.tx_data), 57'd0};
            end
          end
          ST_CS_SETUP: begin
            if (fall_tick) begin
              state <= ST_SHIFT;
              sclk  <= 1'b0;
            end
          end
          ST_SHIFT: begin
            if (rise_tick) begin
              sclk <= 1'b1;
            end
            if (fall_tick) begin
              // End of a high phase: sample, then either advance to the next bit or finish.
              rx_sr <= {rx_sr[62:0], sample_bit};
              if (bit_cnt == last_bit_idx(burst_q)) begin
                state <= ST_CS_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
                sclk    <= 1'b0;
                mosi    <= tx_sr[71];
                tx_sr   <= {tx_sr[70:0], 1'b0};
              end
            end
          end
          ST_CS_HOLD: begin
            if (rise_tick) begin
              state    <= ST_CS_GAP;
              cs_n     <= 1'b1;
              bus.done <= 1'b1;
              if (rw_q && burst_q) begin
                bus.burst_data <= rx_sr;
              end else if (rw_q) begin
                bus.rx_data <= rx_sr[7:0];
              end
            end
          end
          ST_CS_GAP: begin
            if (fall_tick) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmm150_spi_engine.sv
// tb/tb_bmm150_spi_engine.sv - self-checking bench with sensor model and cycle-level reference model
module tb_bmm150_spi_engine;
  import bmm150_spi_pkg::*;

  localparam int H = 25;

`ifdef BMM150_SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic sclk, mosi, cs_n;
  logic miso = 1'b1;

  bmm150_spi_engine_if bus();

  bmm150_spi_engine #(.CLK_HZ(50_000_000), .SPI_CLK(1_000_000)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso),
    .cs_n (cs_n)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sensor: register file, mode 3 slave, answers reads from regs and applies complete writes.
  logic [7:0]  regs [0:127];
  int          s_falls = 0;
  int          s_rise = 0;
  logic [71:0] s_bits = '0;
  logic [7:0]  s_cmd = '0;

  function automatic logic sensor_bit(input int falls, input logic [7:0] cmd);
    int idx, j, b;
    logic [7:0] v;
    idx = (falls == 0) ? 0 : falls - 1;
    if (idx < 8) return 1'b1;
    j = (idx - 8) / 8;
    b = 7 - ((idx - 8) % 8);
    v = regs[(int'(cmd[6:0]) + j) % 128];
    return v[b];
  endfunction

  always @(negedge cs_n) begin
    s_falls = 0;
    s_rise  = 0;
    s_bits  = '0;
  end
  always @(negedge sclk) if (cs_n === 1'b0) s_falls++;
  always @(posedge sclk) if (cs_n === 1'b0) begin
    s_bits = {s_bits[70:0], mosi};
    s_rise++;
    if (s_rise == 8) s_cmd = s_bits[7:0];
  end
  always @(posedge cs_n) if (s_rise == 16 && s_bits[15] == 1'b0) regs[s_bits[14:8]] = s_bits[7:0];
  always @(s_falls, s_cmd) miso = sensor_bit(s_falls, s_cmd);

  // Reference model: transaction timeline as a function of cycles since accept.
  logic        m_act = 1'b0;
  int          m_t = 0;
  int          m_n = 16;
  logic        m_rw = 1'b0;
  logic        m_burst = 1'b0;
  logic [6:0]  m_addr = '0;
  logic [7:0]  m_wd = '0;
  logic [7:0]  m_rx = '0;
  logic [63:0] m_bd = '0;

  function automatic int t_done(input int n);
    return 1 + (2 + 2 * n) * H;
  endfunction

  function automatic logic frame_bit(input int k);
    logic [71:0] f;
    f = {m_rw, m_addr, (m_rw ? 8'h00 : m_wd), 56'h0};
    return f[71 - k];
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_act = 1'b0;
      m_rx  = '0;
      m_bd  = '0;
    end else if (m_act) begin
      if (!bus.enable) begin
        m_act = 1'b0;
      end else begin
        m_t++;
        if (m_t == t_done(m_n) && m_rw) begin
          if (m_burst) begin
            for (int j = 0; j < BURST_BYTES; j++)
              m_bd[63 - 8*j -: 8] = LB ? 8'h00 : regs[(int'(m_addr) + j) % 128];
          end else begin
            m_rx = LB ? 8'h00 : regs[m_addr];
          end
        end
        if (m_t == t_done(m_n) + H) m_act = 1'b0;
      end
    end else if (bus.enable && bus.start) begin
      m_act   = 1'b1;
      m_t     = 1;
      m_rw    = bus.rw;
      m_addr  = bus.reg_addr;
      m_wd    = bus.tx_data;
      m_burst = bus.burst && bus.rw;
      m_n     = m_burst ? 72 : 16;
    end
  end

  // Compare process: every cycle after reset release, mid-cycle.
  logic chk_en = 1'b0;
  logic e_cs, e_sclk, e_busy, e_done;
  int   e_k, e_td;

  always @(negedge clk) begin
    if (chk_en) begin
      e_td = t_done(m_n);
      if (m_act) begin
        e_busy = 1'b1;
        e_cs   = (m_t < e_td) ? 1'b0 : 1'b1;
        e_done = (m_t == e_td);
        e_sclk = (m_t >= 1 + H && m_t < 1 + H + 2 * m_n * H) ? (((m_t - 1 - H) / H) % 2 == 1) : 1'b1;
      end else begin
        e_busy = 1'b0;
        e_cs   = 1'b1;
        e_done = 1'b0;
        e_sclk = 1'b1;
      end
      check("cyc_sclk", 64'(sclk), 64'(e_sclk));
      check("cyc_cs_n", 64'(cs_n), 64'(e_cs));
      check("cyc_busy", 64'(bus.busy), 64'(e_busy));
      check("cyc_done", 64'(bus.done), 64'(e_done));
      check("cyc_rx_data", 64'(bus.rx_data), 64'(m_rx));
      check("cyc_burst_data", bus.burst_data, m_bd);
      if (m_act && !e_cs) begin
        e_k = (m_t < 1 + H) ? 0 : (m_t - 1 - H) / (2 * H);
        if (e_k > m_n - 1) e_k = m_n - 1;
        check("cyc_mosi", 64'(mosi), 64'(frame_bit(e_k)));
      end
    end
  end

  task automatic pulse_start(input logic rw, input logic burst, input logic [6:0] addr, input logic [7:0] wd);
    bus.rw       = rw;
    bus.burst    = burst;
    bus.reg_addr = addr;
    bus.tx_data  = wd;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (bus.done !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    check("done_timeout", 64'(lat < 5000), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < 1000), 64'd1);
  endtask

  int lat;
  int seen_done;

  initial begin
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.burst = 1'b0;
    bus.rw = 1'b0;
    bus.reg_addr = '0;
    bus.tx_data = '0;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h40] = 8'h32;
    for (int i = 0; i < 8; i++) regs[REG_DATA_X_LSB + 7'(i)] = 8'(8'h11 * (i + 1));

    repeat (3) @(negedge clk);
    check("rst_sclk", 64'(sclk), 64'd1);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rx_data", 64'(bus.rx_data), 64'd0);
    check("rst_burst_data", bus.burst_data, 64'd0);
    nrst = 1'b1;
    chk_en = 1'b1;
    bus.enable = 1'b1;
    @(negedge clk);

    // Single read of 0x40.
    pulse_start(1'b1, 1'b0, 7'h40, 8'h00);
    check("rd_cycle1_cs_n", 64'(cs_n), 64'd0);
    check("rd_cycle1_mosi", 64'(mosi), 64'd1);
    wait_done(1, lat);
    check("rd_latency", 64'(lat), 64'd851);
    check("rd_edges", 64'(s_rise), 64'd16);
    check("rd_cmd_byte", 64'(s_bits[15:8]), 64'hC0);
    check("rd_rx_data", 64'(bus.rx_data), LB ? 64'h00 : 64'h32);
    wait_idle();

    // Single write 0x4B <= 0x01.
    pulse_start(1'b0, 1'b0, 7'h4B, 8'h01);
    wait_done(1, lat);
    check("wr_latency", 64'(lat), 64'd851);
    check("wr_edges", 64'(s_rise), 64'd16);
    check("wr_frame", 64'(s_bits[15:0]), 64'h4B01);
    check("wr_rx_kept", 64'(bus.rx_data), LB ? 64'h00 : 64'h32);
    wait_idle();

    // Burst read from the data registers.
    pulse_start(1'b1, 1'b1, REG_DATA_X_LSB, 8'h00);
    wait_done(1, lat);
    check("burst_latency", 64'(lat), 64'd3651);
    check("burst_edges", 64'(s_rise), 64'd72);
    check("burst_data", bus.burst_data, LB ? 64'h0 : 64'h1122334455667788);
    wait_idle();

    // Starts while busy and during the CS gap are ignored; next start lands once busy is low.
    pulse_start(1'b1, 1'b0, 7'h40, 8'h00);
    repeat (98) @(negedge clk);
    pulse_start(1'b0, 1'b0, 7'h4B, 8'hEE);
    wait_done(100, lat);
    check("busy_ign_latency", 64'(lat), 64'd851);
    pulse_start(1'b0, 1'b0, 7'h4B, 8'hEE);
    check("gap_ign_cs_n", 64'(cs_n), 64'd1);
    wait_idle();
    pulse_start(1'b1, 1'b0, REG_DATA_X_LSB, 8'h00);
    check("gap_next_accept", 64'(bus.busy), 64'd1);
    wait_done(1, lat);
    check("next_latency", 64'(lat), 64'd851);
    check("next_rx_data", 64'(bus.rx_data), LB ? 64'h00 : 64'h11);
    wait_idle();

    // Read back the earlier write; the ignored 0xEE writes must not have landed.
    pulse_start(1'b1, 1'b0, 7'h4B, 8'h00);
    wait_done(1, lat);
    check("rdback_rx_data", 64'(bus.rx_data), LB ? 64'h00 : 64'h01);
    wait_idle();

    // Abort mid-shift.
    pulse_start(1'b1, 1'b0, 7'h40, 8'h00);
    repeat (299) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    bus.enable = 1'b1;
    seen_done = 0;
    repeat (900) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_rx_kept", 64'(bus.rx_data), LB ? 64'h00 : 64'h01);

    // Burst flag on a write is ignored: plain 16-bit write.
    pulse_start(1'b0, 1'b1, 7'h4C, 8'h5A);
    wait_done(1, lat);
    check("wburst_latency", 64'(lat), 64'd851);
    check("wburst_edges", 64'(s_rise), 64'd16);
    check("wburst_frame", 64'(s_bits[15:0]), 64'h4C5A);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
